// File: rtl/nn_param_loader_pkg.sv
// rtl/nn_param_loader_pkg.sv - shared encodings and defaults for the parameter loader
package nn_param_loader_pkg;

  localparam logic [1:0] LDR_STA_IDLE = 2'd0;
  localparam logic [1:0] LDR_STA_LOAD = 2'd1;
  localparam logic [1:0] LDR_STA_DONE = 2'd2;

  localparam int WEIGHT_DEPTH_DEF = 6144;
  localparam int BIAS_DEPTH_DEF   = 256;

  localparam logic DEST_WEIGHT = 1'b1;
  localparam logic DEST_BIAS   = 1'b0;

endpackage

// File: rtl/nn_param_loader_addr_gen.sv
// rtl/nn_param_loader_addr_gen.sv - row/slot sequencer with last-word detection
module nn_param_loader_addr_gen
  import nn_param_loader_pkg::*;
#(
  parameter int AW = 13,
  parameter int N  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          dest_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW:0]   count_i,
  input  logic          adv_i,
  output logic [AW-1:0] row_o,
  output logic [4:0]    slot_o,
  output logic          last_o
);

  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] last_row_q, last_row_d;
  logic [4:0]    slot_q, slot_d;
  logic          weight_q, weight_d;

  always_comb begin
    row_d      = row_q;
    slot_d     = slot_q;
    last_row_d = last_row_q;
    weight_d   = weight_q;
    if (load_i) begin
      row_d      = base_i;
      slot_d     = 5'd0;
      // count is nonzero whenever a load happens, so the subtraction cannot wrap
      last_row_d = AW'({1'b0, base_i} + count_i - (AW+1)'(1));
      weight_d   = (dest_i == DEST_WEIGHT);
    end else if (adv_i) begin
      if (weight_q && (slot_q != 5'(N-1))) begin
        slot_d = slot_q + 5'd1;
      end else begin
        slot_d = 5'd0;
        row_d  = row_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q      <= '0;
      slot_q     <= '0;
      last_row_q <= '0;
      weight_q   <= 1'b0;
    end else begin
      row_q      <= row_d;
      slot_q     <= slot_d;
      last_row_q <= last_row_d;
      weight_q   <= weight_d;
    end
  end

  assign row_o  = row_q;
  assign slot_o = slot_q;
  assign last_o = (row_q == last_row_q) && (slot_q == (weight_q ? 5'(N-1) : 5'd0));

endmodule

// File: rtl/nn_param_loader.sv
// rtl/nn_param_loader.sv - packs a word stream into weight/bias RAM row writes
module nn_param_loader
  import nn_param_loader_pkg::*;
#(
  parameter int WIDTH             = 12,
  parameter int MEM_ADR_MAX_WIDTH = 13,
  parameter int N                 = 5,
  parameter int WEIGHT_DEPTH      = WEIGHT_DEPTH_DEF,
  parameter int BIAS_DEPTH        = BIAS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         dest_i,
  input  logic [MEM_ADR_MAX_WIDTH-1:0] base_adr_i,
  input  logic [MEM_ADR_MAX_WIDTH:0]   count_i,
  input  logic                         abort_i,
  input  logic                         in_valid_i,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         in_ready_o,
  output logic                         mem_we_o,
  output logic                         mem_ram_dest_o,
  output logic [MEM_ADR_MAX_WIDTH-1:0] mem_ram_adr_o,
  output logic [4:0]                   mem_ram_adr_offset_o,
  output logic [WIDTH-1:0]             mem_ram_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int AW = MEM_ADR_MAX_WIDTH;
  localparam int SW = MEM_ADR_MAX_WIDTH + 2;

  logic [1:0]       state_q, state_d;
  logic             cmd_dest_q, cmd_dest_d;
  logic             we_q, we_d, done_q, done_d, err_q, err_d;
  logic             mdest_q, mdest_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [4:0]       off_q, off_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load, adv, last;
  logic [AW-1:0]    row;
  logic [4:0]       slot;
  logic [SW-1:0]    end_sum, depth;

  // Widened so base + count never wraps before the depth comparison
  assign end_sum = {2'b00, base_adr_i} + {1'b0, count_i};
  assign depth   = (dest_i == DEST_WEIGHT) ? SW'(WEIGHT_DEPTH) : SW'(BIAS_DEPTH);

  always_comb begin
    state_d    = state_q;
    cmd_dest_d = cmd_dest_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mdest_d    = mdest_q;
    adr_d      = adr_q;
    off_d      = off_q;
    data_d     = data_q;
    load       = 1'b0;
    adv        = 1'b0;
    case (state_q)
      LDR_STA_IDLE: begin
        if (start_i) begin
          cmd_dest_d = dest_i;
          if (end_sum > depth) begin
            err_d = 1'b1;
          end else if (count_i == '0) begin
            state_d = LDR_STA_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LDR_STA_LOAD;
            load    = 1'b1;
          end
        end
      end
      LDR_STA_LOAD: begin
        if (abort_i) begin
          state_d = LDR_STA_IDLE;
        end else if (in_valid_i) begin
          we_d    = 1'b1;
          mdest_d = cmd_dest_q;
          adr_d   = row;
          off_d   = slot;
          data_d  = in_data_i;
          adv     = 1'b1;
          if (last) begin
            state_d = LDR_STA_DONE;
            done_d  = 1'b1;
          end
        end
      end
      LDR_STA_DONE: state_d = LDR_STA_IDLE;
      default:      state_d = LDR_STA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LDR_STA_IDLE;
      cmd_dest_q <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mdest_q    <= 1'b0;
      adr_q      <= '0;
      off_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_dest_q <= cmd_dest_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mdest_q    <= mdest_d;
      adr_q      <= adr_d;
      off_q      <= off_d;
      data_q     <= data_d;
    end
  end

  nn_param_loader_addr_gen #(.AW(AW), .N(N)) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .dest_i (dest_i),
    .base_i (base_adr_i),
    .count_i(count_i),
    .adv_i  (adv),
    .row_o  (row),
    .slot_o (slot),
    .last_o (last)
  );

  assign in_ready_o           = (state_q == LDR_STA_LOAD);
  assign busy_o               = (state_q == LDR_STA_LOAD);
  assign mem_we_o             = we_q;
  assign mem_ram_dest_o       = mdest_q;
  assign mem_ram_adr_o        = adr_q;
  assign mem_ram_adr_offset_o = off_q;
  assign mem_ram_data_o       = data_q;
  assign done_o               = done_q;
  assign err_o                = err_q;

endmodule
